// File: rtl/arith_sched_pkg.sv
// Shared types and constants for the arithmetic loop run controller.
package arith_sched_pkg;

    // Run controller states; S_IDLE must stay the all-zero encoding so reset lands there
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Selector source encodings; 2'd3 falls through to the external selector
    localparam logic [1:0] MODE_EXT  = 2'd0;
    localparam logic [1:0] MODE_ALT  = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One Galois step: shift right, fold the tap mask back in when a one falls out
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/sched_lfsr16.sv
// 16-bit Galois LFSR used as the pseudo-random selector source.
// It only advances when told to, so the sequence is tied to steps rather than to time.
module sched_lfsr16
    import arith_sched_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;

    // Hold the seed out of reset, then step once per advance request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (adv) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/arith_loop_sched.sv
// Run controller for the two-counter arithmetic loop datapath.
// Each run clears the datapath, steps it once per cycle with a generated selector,
// stops on the i bound or the iteration budget, and reports the final i/j.
// Optional feature: define INV_CHK_EN to add the sticky "i must strictly increase" check.
module arith_loop_sched
    import arith_sched_pkg::*;
#(
    parameter int          W         = 15,
    parameter int          CW        = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic          sel_ext,
    input  logic [CW-1:0] max_iter,
    input  logic [W-1:0]  bound,
    input  logic [W-1:0]  dp_i,
    input  logic [W-1:0]  dp_j,
    output logic          dp_rst,
    output logic          dp_en,
    output logic          dp_selector,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] iter_cnt,
    output logic [W-1:0]  final_i,
    output logic [W-1:0]  final_j,
    output logic          inv_err
);

    state_e        state_q, state_d;
    logic [CW-1:0] maxIter_q;
    logic [CW-1:0] iterCnt_q;
    logic [W-1:0]  bound_q;
    logic [W-1:0]  finalI_q;
    logic [W-1:0]  finalJ_q;
    logic          altPhase_q;
    logic          timeout_q;

    logic          loadRun;
    logic          endBound;
    logic          endBudget;
    logic          stepEn;
    logic          clearEn;
    logic          doneEn;
    logic          busyEn;

    logic [15:0]   lfsrQ;
    logic          lfsrBit;
    logic          selRaw;

    // The LFSR advances exactly on the cycles a step is issued, across runs
    sched_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (stepEn),
        .q   (lfsrQ)
    );

    // Only the low bit drives the selector; masking keeps the whole word referenced
    assign lfsrBit = |(lfsrQ & 16'h0001);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control; bound beats budget, abort beats both
    always_comb begin
        state_d   = state_q;
        loadRun   = 1'b0;
        endBound  = 1'b0;
        endBudget = 1'b0;
        stepEn    = 1'b0;
        clearEn   = 1'b0;
        doneEn    = 1'b0;
        busyEn    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    loadRun = 1'b1;
                end
            end
            S_CLEAR: begin
                busyEn  = 1'b1;
                clearEn = 1'b1;
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                busyEn = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dp_i >= bound_q) begin
                    state_d  = S_DONE;
                    endBound = 1'b1;
                end else if (iterCnt_q == maxIter_q) begin
                    state_d   = S_DONE;
                    endBudget = 1'b1;
                end else begin
                    stepEn = 1'b1;
                end
            end
            S_DONE: begin
                busyEn  = 1'b1;
                doneEn  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Run bookkeeping: latch limits at start, count steps, capture results at the end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maxIter_q  <= '0;
            bound_q    <= '0;
            iterCnt_q  <= '0;
            altPhase_q <= 1'b0;
            timeout_q  <= 1'b0;
            finalI_q   <= '0;
            finalJ_q   <= '0;
        end else begin
            if (loadRun) begin
                maxIter_q  <= max_iter;
                bound_q    <= bound;
                iterCnt_q  <= '0;
                altPhase_q <= 1'b0;
                timeout_q  <= 1'b0;
            end
            if (stepEn) begin
                iterCnt_q  <= iterCnt_q + CW'(1);
                altPhase_q <= ~altPhase_q;
            end
            if (endBound || endBudget) begin
                finalI_q  <= dp_i;
                finalJ_q  <= dp_j;
                timeout_q <= endBudget;
            end
        end
    end

    // Selector source mux; mode is read live so a change applies to the next step
    always_comb begin
        selRaw = sel_ext;
        case (mode)
            MODE_ALT:  selRaw = altPhase_q;
            MODE_LFSR: selRaw = lfsrBit;
            default:   selRaw = sel_ext;
        endcase
    end

`ifdef INV_CHK_EN
    logic [W-1:0] prevI_q;
    logic         prevEn_q;
    logic         invErr_q;

    // Sticky flag: after a step, i seen in RUN must be strictly above last cycle's i
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevI_q  <= '0;
            prevEn_q <= 1'b0;
            invErr_q <= 1'b0;
        end else begin
            prevI_q  <= dp_i;
            prevEn_q <= stepEn;
            if ((state_q == S_RUN) && prevEn_q && (dp_i <= prevI_q)) begin
                invErr_q <= 1'b1;
            end
        end
    end

    assign inv_err = invErr_q;
`else
    assign inv_err = 1'b0;
`endif

    assign dp_rst      = clearEn;
    assign dp_en       = stepEn;
    assign dp_selector = stepEn & selRaw;
    assign busy        = busyEn;
    assign done        = doneEn;
    assign timeout     = timeout_q;
    assign iter_cnt    = iterCnt_q;
    assign final_i     = finalI_q;
    assign final_j     = finalJ_q;

endmodule

// File: tb/tb_arith_loop_sched.sv
// Self-checking bench for arith_loop_sched with an incrementing-i datapath model.
// Define INV_CHK_EN to exercise the invariant checker.
module tb_arith_loop_sched;

    localparam int          W    = 15;
    localparam int          CW   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic          sel_ext;
    logic [CW-1:0] max_iter;
    logic [W-1:0]  bound;
    logic [W-1:0]  dpI;
    logic [W-1:0]  dpJ;
    logic          dp_rst;
    logic          dp_en;
    logic          dp_selector;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] iter_cnt;
    logic [W-1:0]  final_i;
    logic [W-1:0]  final_j;
    logic          inv_err;

    int          checks = 0;
    int          errors = 0;
    int          holdAt = -1;
    int          stepIdx = 0;
    logic [15:0] lfsrModel;

    int runSteps;
    int runCyc;
    int runIdleCyc;
    int runDone;
    int runExpJ;

    arith_loop_sched #(
        .W         (W),
        .CW        (CW),
        .LFSR_SEED (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .sel_ext     (sel_ext),
        .max_iter    (max_iter),
        .bound       (bound),
        .dp_i        (dpI),
        .dp_j        (dpJ),
        .dp_rst      (dp_rst),
        .dp_en       (dp_en),
        .dp_selector (dp_selector),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .iter_cnt    (iter_cnt),
        .final_i     (final_i),
        .final_j     (final_j),
        .inv_err     (inv_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Loop datapath model: i counts steps (optionally stalling once), j adds 1 or 2 per step
    always @(posedge clk) begin
        if (dp_rst) begin
            dpI     <= '0;
            dpJ     <= '0;
            stepIdx <= 0;
        end else if (dp_en) begin
            stepIdx <= stepIdx + 1;
            if (stepIdx != holdAt) dpI <= dpI + 15'd1;
            dpJ <= dpJ + (dp_selector ? 15'd2 : 15'd1);
        end
    end

    // Reference LFSR step built from the polynomial exponents
    function automatic logic [15:0] refLfsrNext(input logic [15:0] s);
        int          exps[4] = '{16, 14, 13, 11};
        logic [15:0] mask = '0;
        foreach (exps[n]) mask[exps[n]-1] = 1'b1;
        return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one run and follow it cycle by cycle until done or return to idle
    task automatic applyStimulus(input logic [1:0] m, input int b, input int mi,
                                 input int abortAt, input int restartAt);
        int   cyc;
        logic expSel;
        runSteps   = 0;
        runCyc     = -1;
        runIdleCyc = -1;
        runDone    = 0;
        runExpJ    = 0;
        @(negedge clk);
        mode     = m;
        bound    = W'(b);
        max_iter = CW'(mi);
        start    = 1'b1;
        @(negedge clk);
        cyc = 1;
        start = 1'b0;
        #1;
        checkOutput("clear_dp_rst", 32'(dp_rst), 32'd1);
        for (int k = 0; k < 4000; k++) begin
            abort   = (cyc == abortAt);
            start   = (cyc == restartAt);
            sel_ext = 1'($urandom_range(0, 1));
            #1;
            if (dp_en) begin
                case (m)
                    2'd1:    expSel = runSteps[0];
                    2'd2:    expSel = lfsrModel[0];
                    default: expSel = sel_ext;
                endcase
                checkOutput("selector", 32'(dp_selector), 32'(expSel));
                lfsrModel = refLfsrNext(lfsrModel);
                runExpJ  += expSel ? 2 : 1;
                runSteps++;
            end
            if (done) begin
                runDone = 1;
                runCyc  = cyc;
                break;
            end
            if (!busy) begin
                runIdleCyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    // Expected results for a run on the incrementing datapath, derived from bound and budget
    task automatic checkRunResult(input int b, input int mi);
        int expSteps;
        int expTo;
        expSteps = (b < mi) ? b : mi;
        expTo    = (b > mi) ? 1 : 0;
        checkOutput("run_done", 32'(runDone), 32'd1);
        checkOutput("steps", 32'(runSteps), 32'(expSteps));
        checkOutput("iter_cnt", 32'(iter_cnt), 32'(expSteps));
        checkOutput("timeout", 32'(timeout), 32'(expTo));
        checkOutput("final_i", 32'(final_i), 32'(expSteps));
        checkOutput("final_j", 32'(final_j), 32'(runExpJ));
        checkOutput("done_latency", 32'(runCyc), 32'(expSteps + 3));
        @(negedge clk);
        #1;
        checkOutput("done_pulse", 32'(done), 32'd0);
        checkOutput("idle_after", 32'(busy), 32'd0);
        checkOutput("timeout_hold", 32'(timeout), 32'(expTo));
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lfsrModel = SEED;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 2'd0;
        sel_ext   = 1'b0;
        max_iter  = '0;
        bound     = '0;
        lfsrModel = SEED;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_dp_en", 32'(dp_en), 32'd0);
        checkOutput("reset_iter_cnt", 32'(iter_cnt), 32'd0);
        checkOutput("reset_final_i", 32'(final_i), 32'd0);
        rst = 1'b0;

        $display("[TB] alternate selector, bound stop");
        applyStimulus(2'd1, 10, 100, -1, -1);
        checkRunResult(10, 100);

        $display("[TB] budget stop");
        applyStimulus(2'd0, 15'h7FFF, 5, -1, -1);
        checkRunResult(15'h7FFF, 5);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("timeout_held_idle", 32'(timeout), 32'd1);

        $display("[TB] zero bound and zero budget");
        applyStimulus(2'd1, 0, 20, -1, -1);
        checkRunResult(0, 20);
        applyStimulus(2'd2, 4, 0, -1, -1);
        checkRunResult(4, 0);

        $display("[TB] LFSR runs with and without reset in between");
        pulseReset();
        applyStimulus(2'd2, 12, 50, -1, -1);
        checkRunResult(12, 50);
        pulseReset();
        applyStimulus(2'd2, 12, 50, -1, -1);
        checkRunResult(12, 50);
        applyStimulus(2'd2, 12, 50, -1, -1);
        checkRunResult(12, 50);

        $display("[TB] abort in RUN");
        applyStimulus(2'd1, 100, 100, 4, -1);
        checkOutput("abort_no_done", 32'(runDone), 32'd0);
        checkOutput("abort_idle_cycle", 32'(runIdleCyc), 32'd5);
        checkOutput("abort_iter_cnt", 32'(iter_cnt), 32'd2);
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("abort_quiet", 32'({done, busy, dp_en}), 32'd0);
        end

        $display("[TB] start while busy ignored");
        applyStimulus(2'd3, 8, 50, -1, 4);
        checkRunResult(8, 50);

        $display("[TB] reset mid-run");
        @(negedge clk);
        mode     = 2'd1;
        bound    = 15'd100;
        max_iter = 16'd100;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("midrun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_ctrl", 32'({dp_rst, dp_en, dp_selector, busy, done, timeout, inv_err}), 32'd0);
        checkOutput("rst_iter_cnt", 32'(iter_cnt), 32'd0);
        checkOutput("rst_final_i", 32'(final_i), 32'd0);
        checkOutput("rst_final_j", 32'(final_j), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lfsrModel = SEED;

        $display("[TB] randomized runs");
        for (int r = 0; r < 8; r++) begin
            int rb;
            int rmi;
            logic [1:0] rm;
            rm  = 2'($urandom_range(0, 3));
            rb  = int'($urandom_range(0, 40));
            rmi = int'($urandom_range(0, 40));
            applyStimulus(rm, rb, rmi, -1, -1);
            checkRunResult(rb, rmi);
        end

`ifdef INV_CHK_EN
        $display("[TB] invariant checker");
        holdAt = 2;
        applyStimulus(2'd1, 1000, 6, -1, -1);
        checkOutput("inv_run_done", 32'(runDone), 32'd1);
        checkOutput("inv_err_set", 32'(inv_err), 32'd1);
        holdAt = -1;
        applyStimulus(2'd1, 5, 50, -1, -1);
        checkRunResult(5, 50);
        checkOutput("inv_err_sticky", 32'(inv_err), 32'd1);
`else
        checkOutput("inv_err_tied", 32'(inv_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
